// File: rtl/lc3_regfile_sb.sv
// lc3_regfile_sb
//   Eight-entry LC-3 general-purpose register file with a per-register
//   pending-write scoreboard.
//
//   Ports
//     clk, reset_n       rising-edge clock, asynchronous active-low reset
//     load, dest, in     writeback: write `in` to R[dest], retire one pending write
//     sr1, sr2           read indices
//     sr1_out, sr2_out   read data (writeback value bypassed when dest matches)
//     sr1_busy, sr2_busy register still has an outstanding write after this
//                        cycle's retire
//     reserve,           decode claims a future write to R[reserve_dest]
//     reserve_dest
//     reserve_ok         reservation accepted this cycle
//     sb_err             sticky: a retire hit a register with no pending write
module lc3_regfile_sb #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [2:0]        dest,
  input  logic [DATA_W-1:0] in,
  input  logic [2:0]        sr1,
  input  logic [2:0]        sr2,
  output logic [DATA_W-1:0] sr1_out,
  output logic [DATA_W-1:0] sr2_out,
  output logic              sr1_busy,
  output logic              sr2_busy,
  input  logic              reserve,
  input  logic [2:0]        reserve_dest,
  output logic              reserve_ok,
  output logic              sb_err
);

  localparam logic [1:0] PEND_MAX = 2'd3;

  logic [DATA_W-1:0] regs_q [8];
  logic [DATA_W-1:0] regs_d [8];
  logic [1:0]        pend_q [8];
  logic [1:0]        pend_d [8];
  logic              sb_err_q;
  logic              sb_err_d;

  logic              hit1;
  logic              hit2;
  logic              res_hit;

  function automatic logic [1:0] pend_sat_inc(input logic [1:0] p);
    return (p == PEND_MAX) ? PEND_MAX : p + 2'd1;
  endfunction

  function automatic logic [1:0] pend_sat_dec(input logic [1:0] p);
    return (p == 2'd0) ? 2'd0 : p - 2'd1;
  endfunction

  // Read side: bypass, busy and reservation acceptance from current state
  always_comb begin
    hit1     = load && (dest == sr1);
    hit2     = load && (dest == sr2);
    res_hit  = load && (dest == reserve_dest);

    sr1_out  = hit1 ? in : regs_q[sr1];
    sr2_out  = hit2 ? in : regs_q[sr2];

    // A retire this cycle removes one outstanding write; the count is floored
    // at zero, so "still busy" means more than the retire can cover.
    sr1_busy = pend_q[sr1] > {1'b0, hit1};
    sr2_busy = pend_q[sr2] > {1'b0, hit2};

    // A full counter can still take a reservation when a retire frees a slot
    // on the same register in the same cycle.
    reserve_ok = reserve && ((pend_q[reserve_dest] != PEND_MAX) || res_hit);

    sb_err = sb_err_q;
  end

  // Next-state: register write, scoreboard count update, sticky error
  always_comb begin
    regs_d   = regs_q;
    pend_d   = pend_q;
    sb_err_d = sb_err_q;

    if (load) begin
      regs_d[dest] = in;
      if (pend_q[dest] == 2'd0) begin
        sb_err_d = 1'b1;
      end
    end

    for (int i = 0; i < 8; i++) begin
      logic inc;
      logic dec;
      inc = reserve_ok && (reserve_dest == 3'(i));
      dec = load && (dest == 3'(i));
      // Accepted reserve and retire on the same register cancel out.
      if (inc && !dec) begin
        pend_d[i] = pend_sat_inc(pend_q[i]);
      end else if (dec && !inc) begin
        pend_d[i] = pend_sat_dec(pend_q[i]);
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= '0;
        pend_q[i] <= 2'd0;
      end
      sb_err_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      pend_q   <= pend_d;
      sb_err_q <= sb_err_d;
    end
  end

endmodule

// File: doc/lc3_regfile_sb.md
# lc3_regfile_sb

Eight-entry general-purpose register file for the pipelined LC-3 datapath, with two combinational read ports, one write port with same-cycle write-through bypass, and a per-register pending-write scoreboard. It sits directly upstream of the datapath's 8:1 operand-select stage and supplies the SR1/SR2 operands and busy flags that decode uses to stall. Writeback retires pending writes; decode reserves destinations.

## Interface
- width, 16, data width of each register and of all data ports
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- load  input  1  writeback strobe; write `in` to R[dest] and retire one pending write
- dest  input  3  writeback register index
- in  input  width  writeback data
- sr1  input  3  read port 1 index
- sr2  input  3  read port 2 index
- sr1_out  output  width  read port 1 data
- sr2_out  output  width  read port 2 data
- sr1_busy  output  1  R[sr1] has a pending write not satisfied this cycle
- sr2_busy  output  1  R[sr2] has a pending write not satisfied this cycle
- reserve  input  1  decode claims a future write to R[reserve_dest]
- reserve_dest  input  3  register being reserved
- reserve_ok  output  1  reservation accepted this cycle
- sb_err  output  1  sticky: retire seen on register with zero pending count

## Operation
- Storage: R0..R7, each width bits; pend0..pend7, each 2-bit unsigned pending-write count.
- Read: srN_out = in when load && dest==srN (bypass), else R[srN]. Both ports are independent; sr1==sr2 is legal.
- Write: on clk rise with load=1, R[dest] <= in.
- Retire: load=1 decrements pend[dest] by 1. If pend[dest]==0 the count stays 0 and sb_err sets (sticky until reset); the register write still occurs.
- Reserve: reserve_ok = reserve && (pend[reserve_dest] != 3 || (load && dest==reserve_dest)). On accept, pend[reserve_dest] increments. reserve=1 with reserve_ok=0 changes nothing; decode must hold and retry.
- Same register, reserve accepted and retire in the same cycle: count unchanged. Different registers: both updates apply.
- Busy: srN_busy = (pend[srN] − (load && dest==srN ? 1 : 0)) != 0, computed with the count floored at 0. A register whose final pending write retires this cycle is not busy, because its value is bypassed.
- A reserve in cycle t does not affect busy in cycle t. Busy reflects it from cycle t+1.

## Timing
- Reset (reset_n=0, asynchronous): all R = 0, all pend = 0, sb_err = 0. Consequently sr1_out/sr2_out = 0 (absent bypass), busy = 0, and reserve_ok tracks only `reserve`. Inputs are ignored for state update while reset_n=0. Reset mid-operation discards all pending counts immediately.
- Read and bypass paths are purely combinational, with zero-cycle latency from sr1, sr2, load, dest, and in.
- Write latency: the value is visible via bypass in the cycle it is presented and from storage on the next cycle onward.
- reserve_ok and srN_busy are combinational from the current state and the current inputs. All state updates occur on the clk rising edge.
- Saturation boundary: the count never exceeds 3. An attempted reserve at 3 without a same-cycle retire is refused.
- Underflow boundary: the count never goes below 0. Underflow attempts set sb_err at the edge.

## Test plan
- Reset then read: assert reset_n=0 mid-run after writing R3=0x1234. Required: sr1=3 gives sr1_out=0x0000 immediately and sb_err=0.
- Write/bypass: load=1, dest=5, in=0xBEEF, sr1=5, sr2=5 in the same cycle. Required: both outputs are 0xBEEF that cycle. With load=0 on the next cycle, both are still 0xBEEF.
- Reserve/busy: reserve R2 in cycle 0. Required: sr1_busy=0 in cycle 0 and 1 in cycle 1. Retire R2 with in=0x0042 in cycle 3. Required: sr1_busy=0 and sr1_out=0x0042 in cycle 3.
- Saturation: reserve R7 four times. Required: reserve_ok=1,1,1,0. A fifth reserve in the same cycle as load/dest=7 gives reserve_ok=1, and the count stays 3.
- Multiple pending: with pend[R1]=2, retire R1 once. Required: sr2_busy (sr2=1) stays 1 in that cycle and after. The second retire clears it in its own cycle.
- Underflow: load to R4 with pend=0, in=0x0F0F. Required: R4=0x0F0F and sb_err=1 from the next cycle, persisting through further clean traffic until reset_n=0.
